// File: rtl/wb_bram_pkg.sv
// Shared types and sizing helpers for the pipelined Wishbone BRAM slave.
package wb_bram_pkg;

    // Widest master tag a response stage can carry; narrower tags are zero-extended.
    localparam int unsigned TAG_W_MAX = 8;

    typedef struct packed {
        logic                 valid;
        logic                 miss;
        logic [TAG_W_MAX-1:0] tag;
    } resp_stage_t;

    typedef enum logic {
        INIT,
        READY
    } init_state_e;

    function automatic int unsigned word_bytes(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned depth(input int unsigned bram_addr_width);
        return 32'd1 << bram_addr_width;
    endfunction

    function automatic int unsigned win_lsb(input int unsigned bram_addr_width);
        return bram_addr_width + 2;
    endfunction

endpackage

// File: rtl/wb_bram_core.sv
// Single-port byte-writable word array with a 1- or 2-cycle registered read path.
module wb_bram_core
    import wb_bram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BRAM_ADDR_WIDTH = 14,
    parameter int unsigned RD_LAT          = 1
) (
    input  logic                          i_clk,
    input  logic [BRAM_ADDR_WIDTH-1:0]    i_addr,
    input  logic [DATA_WIDTH/8-1:0]       i_be,
    input  logic [DATA_WIDTH-1:0]         i_wdata,
    input  logic                          i_re,
    output logic [DATA_WIDTH-1:0]         o_rdata
);

    localparam int unsigned WORD_BYTES = word_bytes(DATA_WIDTH);
    localparam int unsigned DEPTH      = depth(BRAM_ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    generate
        if (RD_LAT == 2) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_rdata_out;

            always_ff @(posedge i_clk) begin
                r_rdata_out <= r_rdata;
            end

            assign o_rdata = r_rdata_out;
        end else begin : g_no_out_reg
            assign o_rdata = r_rdata;
        end
    endgenerate

endmodule

// File: rtl/wb_bram_pipelined_slave.sv
// Wishbone B4 pipelined slave around a byte-writable BRAM, returning a master tag with ack/err.
// Define WB_BRAM_INIT_CLEAR_EN to zero the whole array after reset while stalling the bus.
module wb_bram_pipelined_slave
    import wb_bram_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           BRAM_ADDR_WIDTH = 14,
    parameter int unsigned           RD_LAT          = 1,
    parameter int unsigned           TAG_WIDTH       = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_wb_cyc,
    input  logic                    i_wb_stb,
    input  logic                    i_wb_we,
    input  logic [ADDR_WIDTH-1:0]   i_wb_adr,
    input  logic [DATA_WIDTH/8-1:0] i_wb_sel,
    input  logic [DATA_WIDTH-1:0]   i_wb_dat,
    output logic [DATA_WIDTH-1:0]   o_wb_dat,
    output logic                    o_wb_ack,
    output logic                    o_wb_err,
    output logic                    o_wb_stall,
    input  logic [TAG_WIDTH-1:0]    i_tag,
    output logic [TAG_WIDTH-1:0]    o_tag,
    output logic                    o_busy
);

    localparam int unsigned WORD_BYTES = word_bytes(DATA_WIDTH);
    localparam int unsigned WIN_LSB    = win_lsb(BRAM_ADDR_WIDTH);

    logic                       w_stall;
    logic                       w_accept;
    logic                       w_hit;
    logic                       w_req_we;
    logic                       w_req_re;
    logic [BRAM_ADDR_WIDTH-1:0] w_word;
    logic [WORD_BYTES-1:0]      w_req_be;

    logic [BRAM_ADDR_WIDTH-1:0] w_mem_addr;
    logic [WORD_BYTES-1:0]      w_mem_be;
    logic [DATA_WIDTH-1:0]      w_mem_wdata;
    logic                       w_mem_re;

    resp_stage_t                r_stage     [RD_LAT];
    resp_stage_t                w_stage_nxt [RD_LAT];
    resp_stage_t                w_last;
    logic                       w_busy;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_accept = i_wb_cyc & i_wb_stb & ~w_stall;
    assign w_hit    = i_wb_adr[ADDR_WIDTH-1:WIN_LSB] == BASE_ADDR[ADDR_WIDTH-1:WIN_LSB];
    assign w_word   = i_wb_adr[WIN_LSB-1:2];
    assign w_req_we = w_accept & w_hit & i_wb_we;
    assign w_req_re = w_accept & w_hit & ~i_wb_we;
    assign w_req_be = i_wb_sel & {WORD_BYTES{w_req_we}};

`ifdef WB_BRAM_INIT_CLEAR_EN
    localparam int unsigned DEPTH = depth(BRAM_ADDR_WIDTH);

    init_state_e                r_state;
    init_state_e                w_state_nxt;
    logic [BRAM_ADDR_WIDTH-1:0] r_init_cnt;
    logic                       w_init_active;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_init_active) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            INIT: begin
                if (r_init_cnt == BRAM_ADDR_WIDTH'(DEPTH - 1)) begin
                    w_state_nxt = READY;
                end
            end
            READY:   w_state_nxt = READY;
            default: w_state_nxt = INIT;
        endcase
    end

    always_comb begin
        w_init_active = (r_state == INIT);
        w_stall       = w_init_active;
    end

    // The sweep owns the array port while active; bus requests are stalled meanwhile.
    always_comb begin
        w_mem_addr  = w_word;
        w_mem_be    = w_req_be;
        w_mem_wdata = i_wb_dat;
        w_mem_re    = w_req_re;
        if (w_init_active) begin
            w_mem_addr  = r_init_cnt;
            w_mem_be    = '1;
            w_mem_wdata = '0;
            w_mem_re    = 1'b0;
        end
    end
`else
    assign w_stall = 1'b0;

    always_comb begin
        w_mem_addr  = w_word;
        w_mem_be    = w_req_be;
        w_mem_wdata = i_wb_dat;
        w_mem_re    = w_req_re;
    end
`endif

    wb_bram_core #(
        .DATA_WIDTH      (DATA_WIDTH),
        .BRAM_ADDR_WIDTH (BRAM_ADDR_WIDTH),
        .RD_LAT          (RD_LAT)
    ) u_core (
        .i_clk   (i_clk),
        .i_addr  (w_mem_addr),
        .i_be    (w_mem_be),
        .i_wdata (w_mem_wdata),
        .i_re    (w_mem_re),
        .o_rdata (o_wb_dat)
    );

    // ------------------------------------------------------------------
    // Response pipeline: one stage per cycle of read latency
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < RD_LAT; k++) begin
            w_stage_nxt[k] = '0;
        end
        w_stage_nxt[0].valid = w_accept;
        w_stage_nxt[0].miss  = ~w_hit;
        w_stage_nxt[0].tag   = TAG_W_MAX'(i_tag);
        // Dropping cyc aborts everything in flight; accepted writes are already committed.
        for (int k = 1; k < RD_LAT; k++) begin
            w_stage_nxt[k]       = r_stage[k-1];
            w_stage_nxt[k].valid = r_stage[k-1].valid & i_wb_cyc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_stage[k] <= w_stage_nxt[k];
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int k = 0; k < RD_LAT; k++) begin
            w_busy = w_busy | r_stage[k].valid;
        end
    end

    assign w_last     = r_stage[RD_LAT-1];
    assign o_wb_ack   = w_last.valid & ~w_last.miss & i_wb_cyc;
    assign o_wb_err   = w_last.valid & w_last.miss & i_wb_cyc;
    assign o_tag      = w_last.tag[TAG_WIDTH-1:0];
    assign o_busy     = w_busy;
    assign o_wb_stall = w_stall;

    logic w_unused;
    assign w_unused = ^{i_wb_adr[1:0], w_last.tag};

endmodule

// File: tb/tb_wb_bram_pipelined_slave.sv
// Bench driving RD_LAT=1 and RD_LAT=2 instances with shared stimulus against a response-schedule model.
module tb_wb_bram_pipelined_slave;

`ifdef WB_BRAM_INIT_CLEAR_EN
    localparam int BAW     = 4;
    localparam bit INIT_EN = 1'b1;
`else
    localparam int BAW     = 14;
    localparam bit INIT_EN = 1'b0;
`endif
    localparam int DEPTH   = 1 << BAW;
    localparam int WIN_LSB = BAW + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc, stb, we;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic [1:0]  tag;

    logic [31:0] rdat  [2];
    logic        ack   [2];
    logic        err   [2];
    logic        stall [2];
    logic        busy  [2];
    logic [1:0]  otag  [2];

    always #5 clk = ~clk;

    for (genvar l = 0; l < 2; l++) begin : g_dut
        wb_bram_pipelined_slave #(
            .DATA_WIDTH      (32),
            .ADDR_WIDTH      (32),
            .BRAM_ADDR_WIDTH (BAW),
            .RD_LAT          (l + 1),
            .TAG_WIDTH       (2),
            .BASE_ADDR       (32'h0)
        ) u_dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_wb_cyc   (cyc),
            .i_wb_stb   (stb),
            .i_wb_we    (we),
            .i_wb_adr   (adr),
            .i_wb_sel   (sel),
            .i_wb_dat   (wdat),
            .o_wb_dat   (rdat[l]),
            .o_wb_ack   (ack[l]),
            .o_wb_err   (err[l]),
            .o_wb_stall (stall[l]),
            .i_tag      (tag),
            .o_tag      (otag[l]),
            .o_busy     (busy[l])
        );
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: word memory plus a schedule of responses keyed by due cycle.
    typedef struct packed {
        logic        v;
        logic        miss;
        logic        rd;
        logic        known;
        logic [1:0]  tag;
        logic [31:0] dat;
    } exp_t;

    logic [31:0] mem   [DEPTH];
    bit          known [DEPTH];
    exp_t        ring  [2][4];
    int          cyc_n = 0;
    int          init_left = 0;

    task automatic drive(input logic c, input logic s, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b, input logic [1:0] t);
        cyc = c; stb = s; we = w; adr = a; wdat = d; sel = b; tag = t;
    endtask

    task automatic model_check();
        for (int l = 0; l < 2; l++) begin
            exp_t e;
            logic eb;
            int   s;
            s  = cyc_n % 4;
            eb = 1'b0;
            for (int k = 0; k < 4; k++) eb = eb | ring[l][k].v;
            e = ring[l][s];
            if (!cyc) e.v = 1'b0;
            chk($sformatf("busy L%0d c%0d", l + 1, cyc_n), busy[l], eb);
            chk($sformatf("stall L%0d c%0d", l + 1, cyc_n), stall[l], init_left > 0);
            chk($sformatf("ack L%0d c%0d", l + 1, cyc_n), ack[l], e.v & !e.miss);
            chk($sformatf("err L%0d c%0d", l + 1, cyc_n), err[l], e.v & e.miss);
            if (e.v) chk($sformatf("tag L%0d c%0d", l + 1, cyc_n), otag[l], e.tag);
            if (e.v && !e.miss && e.rd && e.known)
                chk($sformatf("rdata L%0d c%0d", l + 1, cyc_n), rdat[l], e.dat);
            ring[l][s].v = 1'b0;
            if (!cyc) for (int k = 0; k < 4; k++) ring[l][k].v = 1'b0;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        if (cyc && stb && init_left == 0) begin
            exp_t e;
            int   w;
            logic hit;
            hit     = (adr >> WIN_LSB) == 32'd0;
            w       = int'((adr >> 2) % DEPTH);
            e.v     = 1'b1;
            e.miss  = !hit;
            e.rd    = !we;
            e.tag   = tag;
            e.dat   = mem[w];
            e.known = known[w];
            if (hit && we) begin
                for (int b = 0; b < 4; b++) if (sel[b]) mem[w][8*b +: 8] = wdat[8*b +: 8];
                if (sel == 4'hF) known[w] = 1'b1;
            end
            for (int l = 0; l < 2; l++) ring[l][(cyc_n + l + 1) % 4] = e;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        if (init_left > 0) init_left--;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    typedef struct {
        logic        cyc, stb, we;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        logic [1:0]  tag;
        logic        e_ack, e_err;
        logic [1:0]  e_tag;
        logic        chk_dat;
        logic [31:0] e_dat;
    } vec_t;

    function automatic vec_t mk(input logic c, input logic s, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] b, input logic [1:0] t,
                                input logic ea, input logic ee, input logic [1:0] et,
                                input logic cd, input logic [31:0] ed);
        vec_t v;
        v.cyc = c; v.stb = s; v.we = w; v.adr = a; v.dat = d; v.sel = b; v.tag = t;
        v.e_ack = ea; v.e_err = ee; v.e_tag = et; v.chk_dat = cd; v.e_dat = ed;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vec [11];
        int   n;

        // Expectations are for the RD_LAT=1 instance in the cycle each row is presented.
        vec[0]  = mk(1, 1, 1, 32'h10,    32'hDEADBEEF, 4'hF, 2, 0, 0, 0, 0, 0);
        vec[1]  = mk(1, 1, 0, 32'h10,    32'h0,        4'hF, 2, 1, 0, 2, 0, 0);
        vec[2]  = mk(1, 0, 0, 32'h0,     32'h0,        4'h0, 0, 1, 0, 2, 1, 32'hDEADBEEF);
        vec[3]  = mk(1, 1, 1, 32'h20,    32'h11223344, 4'hF, 1, 0, 0, 0, 0, 0);
        vec[4]  = mk(1, 1, 1, 32'h20,    32'hAA000000, 4'h8, 0, 1, 0, 1, 0, 0);
        vec[5]  = mk(1, 1, 0, 32'h22,    32'h0,        4'hF, 3, 1, 0, 0, 0, 0);
        vec[6]  = mk(1, 1, 1, 32'h10010, 32'h12345678, 4'hF, 1, 1, 0, 3, 1, 32'hAA223344);
        vec[7]  = mk(1, 1, 0, 32'h10010, 32'h0,        4'hF, 2, 0, 1, 1, 0, 0);
        vec[8]  = mk(1, 1, 0, 32'h10,    32'h0,        4'hF, 0, 0, 1, 2, 0, 0);
        vec[9]  = mk(1, 0, 0, 32'h0,     32'h0,        4'h0, 0, 1, 0, 0, 1, 32'hDEADBEEF);
        vec[10] = mk(0, 0, 0, 32'h0,     32'h0,        4'h0, 0, 0, 0, 0, 0, 0);

        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            known[i] = 1'b0;
        end
        for (int l = 0; l < 2; l++) for (int k = 0; k < 4; k++) ring[l][k] = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            chk($sformatf("reset ack L%0d", l + 1), ack[l], 0);
            chk($sformatf("reset err L%0d", l + 1), err[l], 0);
            chk($sformatf("reset tag L%0d", l + 1), otag[l], 0);
            chk($sformatf("reset busy L%0d", l + 1), busy[l], 0);
            chk($sformatf("reset stall L%0d", l + 1), stall[l], INIT_EN);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc_n = 0;
        if (INIT_EN) begin
            init_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] = '0;
                known[i] = 1'b1;
            end

            // Read pending while the clear sweep runs: stalled, then accepted and returns zero.
            drive(1, 1, 0, 32'h4, 0, 4'hF, 1);
            n = 0;
            while (stall[0] === 1'b1 && n < 100) begin
                step();
                n++;
            end
            chk("init stall cycles", n, DEPTH);
            step();
            drive(1, 0, 0, 0, 0, 0, 0);
            sample();
            chk("init read ack L1", ack[0], 1);
            chk("init read data L1", rdat[0], 0);
            advance();
            sample();
            chk("init read ack L2", ack[1], 1);
            chk("init read data L2", rdat[1], 0);
            advance();
        end

        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (3) step();

        for (int i = 0; i < 11; i++) begin
            drive(vec[i].cyc, vec[i].stb, vec[i].we, vec[i].adr, vec[i].dat, vec[i].sel,
                  vec[i].tag);
            sample();
            chk($sformatf("vec%0d ack", i), ack[0], vec[i].e_ack);
            chk($sformatf("vec%0d err", i), err[0], vec[i].e_err);
            if (vec[i].e_ack || vec[i].e_err) chk($sformatf("vec%0d tag", i), otag[0], vec[i].e_tag);
            if (vec[i].chk_dat) chk($sformatf("vec%0d data", i), rdat[0], vec[i].e_dat);
            advance();
        end

        // Four back-to-back reads on the RD_LAT=2 instance.
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'hF, 0);
            step();
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive(1, 1, 0, 32'(i * 4), 0, 4'hF, 2'(i));
            else drive(1, 0, 0, 0, 0, 0, 0);
            sample();
            if (i >= 2) begin
                chk($sformatf("burst ack %0d", i - 2), ack[1], 1);
                chk($sformatf("burst tag %0d", i - 2), otag[1], 32'(i - 2));
                chk($sformatf("burst data %0d", i - 2), rdat[1], 32'hC0DE_0000 + 32'(i - 2));
            end else begin
                chk($sformatf("burst early ack %0d", i), ack[1], 0);
            end
            advance();
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (2) step();

        // Two reads then cyc dropped: RD_LAT=2 answers neither and drains.
        drive(1, 1, 0, 32'h0, 0, 4'hF, 1);
        step();
        drive(1, 1, 0, 32'h4, 0, 4'hF, 2);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        sample();
        chk("abort ack", ack[1], 0);
        chk("abort err", err[1], 0);
        advance();
        drive(1, 0, 0, 0, 0, 0, 0);
        sample();
        chk("abort busy", busy[1], 0);
        chk("abort late ack", ack[1], 0);
        advance();

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 9) == 0)
                a = (32'($urandom_range(1, 255)) << WIN_LSB) | 32'($urandom_range(0, 63));
            else
                a = 32'($urandom_range(0, 63));
            drive($urandom_range(0, 15) != 0, $urandom_range(0, 9) < 7, 1'($urandom),
                  a, $urandom, 4'($urandom), 2'($urandom));
            step();
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
